// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM core pipeline control logic.
package arm_pkg;

  localparam int REG_IDX_W   = 4;
  localparam int WAIT_CNT_W  = 8;
  localparam int STALL_CNT_W = 16;

  // Pipeline sequencer states: normal flow, waiting on SRAM, dead on SRAM timeout.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } ctrl_state_t;

  // True when a stage that writes a register targets the given source index.
  // Register 0 is an ordinary register here, so no index is excluded.
  function automatic logic reg_match(input logic                 wb_en,
                                     input logic [REG_IDX_W-1:0] dest,
                                     input logic [REG_IDX_W-1:0] src);
    return wb_en & (dest == src);
  endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// RAW hazard detector: compares the ID sources against the EXE and MEM
// destinations. Without forwarding every match stalls; with forwarding only
// a load in EXE (whose data is not ready yet) forces a stall.
import arm_pkg::*;

module hazard_detect_unit #(
  parameter bit FORWARD_EN = 1'b0
) (
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 two_src,
  input  logic                 exe_wb_en,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_mem_read,
  input  logic                 mem_wb_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  output logic                 raw
);

  logic exe_src1;
  logic exe_src2;
  logic mem_src1;
  logic mem_src2;

  // Per-source match terms; src2 only counts when it is a live operand.
  always_comb begin
    exe_src1 = reg_match(exe_wb_en, exe_dest, src1);
    exe_src2 = two_src & reg_match(exe_wb_en, exe_dest, src2);
    mem_src1 = reg_match(mem_wb_en, mem_dest, src1);
    mem_src2 = two_src & reg_match(mem_wb_en, mem_dest, src2);
  end

  // Combine the terms according to whether a forwarding network exists.
  always_comb begin
    raw = 1'b0;
    if (FORWARD_EN) begin
      raw = exe_mem_read & (exe_src1 | exe_src2);
    end else begin
      raw = exe_src1 | exe_src2 | mem_src1 | mem_src2;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: RAW hazard bubbles, SRAM wait freezing,
// branch flushes, a sticky SRAM timeout flag and a saturating stall counter.
//
// SRAM handshake: mem_access is held by the MEM stage for the whole request;
// mem_ready is a one-cycle completion pulse. The cycle carrying mem_ready is
// an unfrozen cycle, so the pipeline advances on the edge that ends it. A
// mem_ready seen in RUN with no mem_access is ignored.
import arm_pkg::*;

module pipeline_ctrl #(
  parameter bit FORWARD_EN  = 1'b0,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_IDX_W-1:0]   src1,
  input  logic [REG_IDX_W-1:0]   src2,
  input  logic                   two_src,
  input  logic                   exe_wb_en,
  input  logic [REG_IDX_W-1:0]   exe_dest,
  input  logic                   exe_mem_read,
  input  logic                   mem_wb_en,
  input  logic [REG_IDX_W-1:0]   mem_dest,
  input  logic                   branch_taken,
  input  logic                   mem_access,
  input  logic                   mem_ready,
  output logic                   hazard,
  output logic                   freeze,
  output logic                   flush,
  output logic                   stall_pipe,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output ctrl_state_t            dbg_state
);

  // The first waiting cycle happens in RUN and loads wait_cnt to 1, so in
  // MEM_WAIT the current waiting cycle is number wait_cnt+1. Timeout fires
  // at the end of waiting cycle MEM_TIMEOUT.
  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t            state_q,     state_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q,  wait_cnt_d;
  logic                   mem_err_q,   mem_err_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   raw;

  hazard_detect_unit #(
    .FORWARD_EN (FORWARD_EN)
  ) u_hazard (
    .src1         (src1),
    .src2         (src2),
    .two_src      (two_src),
    .exe_wb_en    (exe_wb_en),
    .exe_dest     (exe_dest),
    .exe_mem_read (exe_mem_read),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .raw          (raw)
  );

  // State, wait counter, sticky error and stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic and the pipeline-wide freeze for SRAM accesses.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall_pipe = 1'b0;
    case (state_q)
      RUN: begin
        stall_pipe = mem_access & ~mem_ready;
        if (mem_access && !mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        stall_pipe = ~mem_ready;
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q >= TIMEOUT_LIM) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      ERR: begin
        stall_pipe = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Stage control outputs: a frozen pipeline neither flushes nor bubbles,
  // and a flushed ID instruction needs no bubble.
  always_comb begin
    flush  = branch_taken & ~stall_pipe;
    hazard = raw & ~stall_pipe & ~flush;
    freeze = hazard | stall_pipe;
  end

  // Sticky error rises the cycle after ERR is entered; stall counter saturates.
  always_comb begin
    mem_err_d   = mem_err_q | (state_q == ERR);
    stall_cnt_d = stall_cnt_q;
    if (freeze && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Two instances share every input: one
// without forwarding, one with forwarding; both use a short SRAM timeout.
import arm_pkg::*;

module tb_pipeline_ctrl;

  typedef struct packed {
    logic        haz;
    logic        flush;
    logic        freeze;
    logic        stall;
    logic        err;
    logic [15:0] cnt;
    logic [1:0]  st;
  } obs_t;

  typedef struct packed {
    obs_t d0;
    obs_t d1;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  src1, src2, exe_dest, mem_dest;
  logic        two_src, exe_wb_en, exe_mem_read, mem_wb_en;
  logic        branch_taken, mem_access, mem_ready;

  logic        haz0, frz0, fl0, stl0, err0;
  logic [15:0] cnt0;
  ctrl_state_t st0;
  logic        haz1, frz1, fl1, stl1, err1;
  logic [15:0] cnt1;
  ctrl_state_t st1;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors;
  int    miscompares;

  pipeline_ctrl #(.FORWARD_EN(1'b0), .MEM_TIMEOUT(4)) dut0 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .branch_taken(branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .hazard(haz0), .freeze(frz0), .flush(fl0), .stall_pipe(stl0),
    .mem_err(err0), .stall_cnt(cnt0), .dbg_state(st0)
  );

  pipeline_ctrl #(.FORWARD_EN(1'b1), .MEM_TIMEOUT(4)) dut1 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .branch_taken(branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .hazard(haz1), .freeze(frz1), .flush(fl1), .stall_pipe(stl1),
    .mem_err(err1), .stall_cnt(cnt1), .dbg_state(st1)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1;
  end

  // Driver: one vector per cycle, inputs applied just after the rising edge,
  // expected outputs for that cycle pushed at the same time.
  task automatic drv(input string nm, input logic r,
                     input logic [3:0] s1, input logic [3:0] s2, input logic two,
                     input logic ewb, input logic [3:0] ed, input logic erd,
                     input logic mwb, input logic [3:0] md,
                     input logic br, input logic acc, input logic rdy,
                     input logic h0, input logic h1, input logic fl,
                     input logic fz0, input logic fz1, input logic stl, input logic er,
                     input logic [15:0] c0, input logic [15:0] c1, input ctrl_state_t st);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; src1 = s1; src2 = s2; two_src = two;
    exe_wb_en = ewb; exe_dest = ed; exe_mem_read = erd;
    mem_wb_en = mwb; mem_dest = md;
    branch_taken = br; mem_access = acc; mem_ready = rdy;
    e.d0 = '{haz: h0, flush: fl, freeze: fz0, stall: stl, err: er, cnt: c0, st: st};
    e.d1 = '{haz: h1, flush: fl, freeze: fz1, stall: stl, err: er, cnt: c1, st: st};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard: compares outputs mid-cycle whenever a vector is pending.
  always @(negedge clk) begin
    exp_t  e;
    obs_t  a0;
    obs_t  a1;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a0 = '{haz: haz0, flush: fl0, freeze: frz0, stall: stl0, err: err0, cnt: cnt0, st: st0};
      a1 = '{haz: haz1, flush: fl1, freeze: frz1, stall: stl1, err: err1, cnt: cnt1, st: st1};
      vectors++;
      if (a0 !== e.d0) begin
        miscompares++;
        $display("FAIL %s fwd0: got haz=%b fl=%b frz=%b stl=%b err=%b cnt=%0d st=%0d, want haz=%b fl=%b frz=%b stl=%b err=%b cnt=%0d st=%0d",
                 nm, a0.haz, a0.flush, a0.freeze, a0.stall, a0.err, a0.cnt, a0.st,
                 e.d0.haz, e.d0.flush, e.d0.freeze, e.d0.stall, e.d0.err, e.d0.cnt, e.d0.st);
      end
      vectors++;
      if (a1 !== e.d1) begin
        miscompares++;
        $display("FAIL %s fwd1: got haz=%b fl=%b frz=%b stl=%b err=%b cnt=%0d st=%0d, want haz=%b fl=%b frz=%b stl=%b err=%b cnt=%0d st=%0d",
                 nm, a1.haz, a1.flush, a1.freeze, a1.stall, a1.err, a1.cnt, a1.st,
                 e.d1.haz, e.d1.flush, e.d1.freeze, e.d1.stall, e.d1.err, e.d1.cnt, e.d1.st);
      end
    end
  end

  // Directed vectors. Columns:
  //   name, rst, src1,src2,two, ewb,edest,eload, mwb,mdest, br,acc,rdy |
  //   haz0,haz1,flush,frz0,frz1,stall,err, cnt0,cnt1, state
  initial begin
    vectors = 0;
    miscompares = 0;
    src1 = '0; src2 = '0; two_src = 1'b0;
    exe_wb_en = 1'b0; exe_dest = '0; exe_mem_read = 1'b0;
    mem_wb_en = 1'b0; mem_dest = '0;
    branch_taken = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;

    drv("reset",         1, 0,0,0, 0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0,0,  0, 0, RUN);
    drv("idle",          0, 0,0,0, 0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0,0,  0, 0, RUN);
    drv("raw_exe",       0, 3,0,0, 1,3,0, 0,0, 0,0,0,  1,0,0,1,0,0,0,  0, 0, RUN);
    drv("raw_mem",       0, 3,0,0, 0,0,0, 1,3, 0,0,0,  1,0,0,1,0,0,0,  1, 0, RUN);
    drv("fwd_alu",       0, 0,5,1, 1,5,0, 0,0, 0,0,0,  1,0,0,1,0,0,0,  2, 0, RUN);
    drv("fwd_load",      0, 0,5,1, 1,5,1, 0,0, 0,0,0,  1,1,0,1,1,0,0,  3, 0, RUN);
    drv("fwd_one_src",   0, 0,5,0, 1,5,1, 0,0, 0,0,0,  0,0,0,0,0,0,0,  4, 1, RUN);
    drv("reg0_match",    0, 0,0,0, 0,0,0, 1,0, 0,0,0,  1,0,0,1,0,0,0,  4, 1, RUN);
    drv("sram_req",      0, 0,0,0, 0,0,0, 0,0, 0,1,0,  0,0,0,1,1,1,0,  5, 1, RUN);
    drv("sram_wait1",    0, 0,0,0, 0,0,0, 0,0, 0,1,0,  0,0,0,1,1,1,0,  6, 2, MEM_WAIT);
    drv("sram_br_held",  0, 3,0,0, 1,3,0, 0,0, 1,1,0,  0,0,0,1,1,1,0,  7, 3, MEM_WAIT);
    drv("sram_ready_br", 0, 3,0,0, 1,3,1, 0,0, 1,1,1,  0,0,1,0,0,0,0,  8, 4, MEM_WAIT);
    drv("back_in_run",   0, 0,0,0, 0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0,0,  8, 4, RUN);
    drv("fast_path",     0, 0,0,0, 0,0,0, 0,0, 0,1,1,  0,0,0,0,0,0,0,  8, 4, RUN);
    drv("fast_after",    0, 0,0,0, 0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0,0,  8, 4, RUN);
    drv("ready_no_acc",  0, 0,0,0, 0,0,0, 0,0, 0,0,1,  0,0,0,0,0,0,0,  8, 4, RUN);
    drv("flush_over_raw",0, 3,0,0, 1,3,1, 0,0, 1,0,0,  0,0,1,0,0,0,0,  8, 4, RUN);
    drv("to_wait0",      0, 0,0,0, 0,0,0, 0,0, 0,1,0,  0,0,0,1,1,1,0,  8, 4, RUN);
    drv("to_wait1",      0, 0,0,0, 0,0,0, 0,0, 0,1,0,  0,0,0,1,1,1,0,  9, 5, MEM_WAIT);
    drv("to_wait2",      0, 0,0,0, 0,0,0, 0,0, 0,1,0,  0,0,0,1,1,1,0, 10, 6, MEM_WAIT);
    drv("to_wait3",      0, 0,0,0, 0,0,0, 0,0, 0,1,0,  0,0,0,1,1,1,0, 11, 7, MEM_WAIT);
    drv("err_entry",     0, 0,0,0, 0,0,0, 0,0, 0,0,0,  0,0,0,1,1,1,0, 12, 8, ERR);
    drv("err_flag",      0, 0,0,0, 0,0,0, 0,0, 1,0,1,  0,0,0,1,1,1,1, 13, 9, ERR);
    drv("err_stuck",     0, 0,0,0, 0,0,0, 0,0, 0,0,0,  0,0,0,1,1,1,1, 14,10, ERR);
    drv("rst_in_err",    1, 0,0,0, 0,0,0, 0,0, 0,1,0,  0,0,0,1,1,1,0,  0, 0, RUN);
    drv("rst_release",   0, 0,0,0, 0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0,0,  0, 0, RUN);
    drv("mw_req",        0, 0,0,0, 0,0,0, 0,0, 0,1,0,  0,0,0,1,1,1,0,  0, 0, RUN);
    drv("mw_wait",       0, 0,0,0, 0,0,0, 0,0, 0,1,0,  0,0,0,1,1,1,0,  1, 1, MEM_WAIT);
    drv("mw_rst",        1, 0,0,0, 0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0,0,  0, 0, RUN);
    drv("mw_after",      0, 0,0,0, 0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0,0,  0, 0, RUN);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending vectors, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencer for the 5-stage ARM core. Detects RAW hazards between the register sources being decoded in ID and the destinations in flight in EXE/MEM, and drives the `hazard` input of the ID stage. It also sequences multi-cycle SRAM accesses from the MEM stage by freezing the whole pipeline, and issues flushes on taken branches. It keeps a sticky SRAM-timeout error flag and a saturating stall-cycle counter.

## Interface
- `FORWARD_EN`, 0: 1 = forwarding unit present, so only load-use hazards stall; 0 = every RAW match stalls.
- `MEM_TIMEOUT`, 64: maximum number of MEM_WAIT cycles before the error flag is raised; legal range 2..255.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `src1` in 4: Rn index from ID.
- `src2` in 4: second source index from ID.
- `two_src` in 1: `src2` is a live operand.
- `exe_wb_en` in 1: the EXE-stage instruction writes a register.
- `exe_dest` in 4: EXE-stage destination register.
- `exe_mem_read` in 1: the EXE-stage instruction is a load.
- `mem_wb_en` in 1: the MEM-stage instruction writes a register.
- `mem_dest` in 4: MEM-stage destination register.
- `branch_taken` in 1: the EXE stage resolved a taken branch.
- `mem_access` in 1: the MEM stage requests SRAM (read or write).
- `mem_ready` in 1: SRAM completion; a one-cycle pulse.
- `hazard` out 1: to ID; zeroes the control bits and holds IF/PC.
- `freeze` out 1: hold enable for PC and the IF/ID register.
- `flush` out 1: clear IF/ID and ID/EX.
- `stall_pipe` out 1: hold every pipeline register (IF through MEM/WB).
- `mem_err` out 1: sticky SRAM timeout flag.
- `stall_cnt` out 16: saturating count of stalled cycles.

## Operation
- **RAW match on a source s** (`src1` always; `src2` only when `two_src`=1):
  - EXE term: `exe_wb_en` & `exe_dest`==s.
  - MEM term: `mem_wb_en` & `mem_dest`==s.
- **`raw` with `FORWARD_EN`=0:** OR of the EXE and MEM terms over all live sources.
- **`raw` with `FORWARD_EN`=1:** EXE terms only, each qualified by `exe_mem_read`.
- **FSM states:** RUN, MEM_WAIT, ERR.
- **RUN:**
  - `stall_pipe` = `mem_access` & ~`mem_ready`.
  - `mem_access` & ~`mem_ready` → MEM_WAIT, with `wait_cnt` loaded to 1.
  - `mem_access` & `mem_ready` in the same cycle (fast path): no stall, stay in RUN.
- **MEM_WAIT:**
  - `stall_pipe` = ~`mem_ready`.
  - `mem_ready`=1 → RUN.
  - Otherwise `wait_cnt`++; on reaching `MEM_TIMEOUT` with no ready → ERR.
- **ERR:** `stall_pipe`=1 and `mem_err`=1 permanently; leaves only on `rst`.
- **`hazard`** = `raw` & ~`stall_pipe` & ~`flush`.
  - A frozen pipeline does not also bubble.
  - A flushed ID instruction is discarded anyway.
- **`flush`** = `branch_taken` & ~`stall_pipe`.
  - A branch held in a frozen EXE flushes on the first unfrozen cycle.
- **`freeze`** = `hazard` | `stall_pipe`.
- **`stall_cnt`:** increments on each cycle with `hazard` | `stall_pipe`; saturates at 16'hFFFF.
- **Priority:** `stall_pipe` > `flush` > `hazard`.
- **Register 0 carries no special meaning;** index 0 matches like any other register.

## Timing
- `hazard`, `flush` and `freeze` are combinational from the inputs and the current state; they take effect in the same cycle.
- `stall_pipe` is combinational from `mem_access`, `mem_ready` and the state.
  - The first stall cycle is the cycle `mem_access` rises.
  - The pipeline advances on the edge ending the cycle in which `mem_ready`=1.
- A request satisfied after k cycles of wait stalls exactly k cycles (k = cycles with `mem_ready`=0).
- **Timeout:** the transition to ERR occurs at the edge after the `MEM_TIMEOUT`-th waiting cycle. `mem_err` is registered and rises 1 cycle later than that edge.
- **Reset values:**
  - State = RUN; `wait_cnt`=0; `mem_err`=0; `stall_cnt`=0.
  - The combinational outputs follow from those values and the inputs.
- **Reset mid-MEM_WAIT:** returns to RUN immediately and asynchronously; `stall_pipe` drops unless `mem_access` is still high.
- **`mem_ready` without `mem_access` in RUN:** ignored.

## Structure
- The shared package `arm_pkg` holds:
  - the `ctrl_state_t` enum (RUN, MEM_WAIT, ERR);
  - the `REG_IDX_W`=4 constant.
- Sub-module `hazard_detect_unit`: purely combinational; inputs are the sources and dests plus `FORWARD_EN`; output is `raw`.
- The top level holds the FSM, `wait_cnt` (8 bits), `mem_err` and `stall_cnt`.

## Test plan
- **Plain RAW stall:** `FORWARD_EN`=0; `src1`=3, `exe_wb_en`=1, `exe_dest`=3 → `hazard`=1 and `freeze`=1 in the same cycle; `stall_cnt` 0→1.
- **Forwarding:** `FORWARD_EN`=1; `src2`=5, `two_src`=1, `exe_dest`=5, `exe_mem_read`=0 → `hazard`=0. Same case with `exe_mem_read`=1 → `hazard`=1. Same case with `two_src`=0 → `hazard`=0.
- **SRAM wait:** `mem_access`=1, then `mem_ready` pulses on the 4th cycle → `stall_pipe`=1 for exactly 3 cycles and 0 in the ready cycle; state is back in RUN.
- **Fast path:** `mem_access`=1 and `mem_ready`=1 in the same cycle → no stall, `stall_cnt` unchanged.
- **Branch during stall:** `branch_taken`=1 while `stall_pipe`=1 → `flush`=0. In the ready cycle → `flush`=1 and `hazard`=0 even with a RAW match present.
- **Timeout and reset:** `MEM_TIMEOUT`=4, `mem_ready` never arrives → ERR state, `mem_err`=1, `stall_pipe` stuck at 1. Assert `rst` mid-ERR → `mem_err`=0 and `stall_cnt`=0 immediately.
